// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst reader: FSM encoding, default widths
// and the FIFO occupancy helper used by the read-issue flow control.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [1:0] fifo_occupancy(input logic full, input logic empty);
    return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/mem_burst_reader_if.sv
// Command, memory-read and AXI-Stream signals of the burst reader.
// master is the reader itself, slave is the surrounding system.
interface mem_burst_reader_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [LEN_WIDTH-1:0]      cmd_len;
  logic                      m02_axis_rd_en;
  logic [ADDR_WIDTH-1:0]     m02_axis_rd_addr;
  logic [DATA_WIDTH-1:0]     m02_axis_rd_tdata;
  logic [DATA_WIDTH-1:0]     m03_axis_tdata;
  logic [DATA_WIDTH/8-1:0]   m03_axis_tstrb;
  logic                      m03_axis_tvalid;
  logic                      m03_axis_tlast;
  logic                      m03_axis_tready;
  logic                      busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, m02_axis_rd_tdata, m03_axis_tready,
    output cmd_ready, m02_axis_rd_en, m02_axis_rd_addr,
           m03_axis_tdata, m03_axis_tstrb, m03_axis_tvalid, m03_axis_tlast, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, m02_axis_rd_tdata, m03_axis_tready,
    input  cmd_ready, m02_axis_rd_en, m02_axis_rd_addr,
           m03_axis_tdata, m03_axis_tstrb, m03_axis_tvalid, m03_axis_tlast, busy
  );

endinterface

// File: rtl/axis_fifo2.sv
// Two-entry output FIFO; push and pop in the same cycle keep occupancy unchanged.
module axis_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the head slot the write pointer aims at.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/mem_burst_reader.sv
// Reads cmd_len+1 consecutive memory words and streams them out over AXI-Stream,
// throttling reads so the 2-entry output FIFO can never overflow.
//
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_READ  | issuing reads while FIFO room allows
//   ST_DRAIN | all reads issued, waiting for in-flight data and FIFO to empty
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic m03_axis_aclk,
  input  logic m03_axis_areset,
  mem_burst_reader_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic                  pend;
  logic                  pend_last;
  logic                  cmd_ready_r;
  logic                  busy_r;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH:0]   head;
  logic                  full;
  logic                  empty;

  // Occupancy after this edge; a new read is safe if its word still fits with no further pops.
  assign pop        = ~empty & bus.m03_axis_tready;
  assign occ_next   = fifo_occupancy(full, empty) + {1'b0, pend} - {1'b0, pop};
  assign issue      = (state == ST_READ) && (occ_next <= 2'd1);
  assign issue_last = issue && (issue_cnt == '0);

  always_ff @(posedge m03_axis_aclk or posedge m03_axis_areset) begin
    if (m03_axis_areset) begin
      state       <= ST_IDLE;
      addr_cnt    <= '0;
      issue_cnt   <= '0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue_last;
      case (state)
        ST_IDLE: begin
          cmd_ready_r <= 1'b1;
          if (bus.cmd_valid && cmd_ready_r) begin
            addr_cnt    <= bus.cmd_addr;
            issue_cnt   <= bus.cmd_len;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            if (issue_cnt == '0) state <= ST_DRAIN;
            else issue_cnt <= issue_cnt - LEN_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (empty && !pend) begin
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (m03_axis_aclk),
    .rst      (m03_axis_areset),
    .push     (pend),
    .push_data({pend_last, bus.m02_axis_rd_tdata}),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign bus.cmd_ready        = cmd_ready_r;
  assign bus.busy             = busy_r;
  assign bus.m02_axis_rd_en   = issue;
  assign bus.m02_axis_rd_addr = addr_cnt;
  assign bus.m03_axis_tvalid  = ~empty;
  assign bus.m03_axis_tdata   = head[DATA_WIDTH-1:0];
  assign bus.m03_axis_tlast   = ~empty & head[DATA_WIDTH];
  assign bus.m03_axis_tstrb   = {STRB_WIDTH{~empty}};

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: one-cycle-latency memory model plus
// address and beat scoreboards filled when each command is driven.
module tb_mem_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_reader_if bus ();

  mem_burst_reader dut (
    .m03_axis_aclk  (clk),
    .m03_axis_areset(rst),
    .bus            (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int rd_cnt = 0;
  logic [11:0] addr_q[$];
  logic [32:0] beat_q[$];
  logic        stall_prev = 1'b0;
  logic [32:0] prev_beat = '0;

  function automatic logic [31:0] data_of(input logic [11:0] a);
    return {8'h5A, a, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory: data valid the cycle after rd_en, garbage otherwise
  always @(posedge clk)
    bus.m02_axis_rd_tdata <= bus.m02_axis_rd_en ? data_of(bus.m02_axis_rd_addr) : 32'hDEADBEEF;

  always @(negedge clk) begin
    logic [11:0] ea;
    logic [32:0] eb;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.m02_axis_rd_en) begin
        rd_cnt++;
        if (addr_q.size() != 0) ea = addr_q.pop_front();
        else ea = 'x;
        check("rd_addr", bus.m02_axis_rd_addr, ea);
      end
      if (stall_prev) begin
        check("hold_tvalid", bus.m03_axis_tvalid, 1);
        check("hold_beat", {bus.m03_axis_tlast, bus.m03_axis_tdata}, prev_beat);
      end
      if (bus.m03_axis_tvalid && bus.m03_axis_tready) begin
        beat_cnt++;
        if (beat_q.size() != 0) eb = beat_q.pop_front();
        else eb = 'x;
        check("beat", {bus.m03_axis_tlast, bus.m03_axis_tdata}, eb);
        check("tstrb", bus.m03_axis_tstrb, 4'hF);
      end
      stall_prev = bus.m03_axis_tvalid & ~bus.m03_axis_tready;
      prev_beat  = {bus.m03_axis_tlast, bus.m03_axis_tdata};
    end
  end

  task automatic send_cmd(input logic [11:0] a, input logic [11:0] l);
    int g = 0;
    logic [11:0] ai;
    while (bus.cmd_ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("cmd_ready_wait", g < 100, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + 12'(i);
      addr_q.push_back(ai);
      beat_q.push_back({(i == int'(l)), data_of(ai)});
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    @(negedge clk);
    while ((bus.busy || !bus.cmd_ready) && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("idle_reached", g < budget, 1);
    check("beats_left", beat_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_cmd_ready", bus.cmd_ready, exp_ready);
    check("rst_rd_en", bus.m02_axis_rd_en, 0);
    check("rst_rd_addr", bus.m02_axis_rd_addr, 0);
    check("rst_tvalid", bus.m03_axis_tvalid, 0);
    check("rst_tlast", bus.m03_axis_tlast, 0);
    check("rst_tdata", bus.m03_axis_tdata, 0);
    check("rst_tstrb", bus.m03_axis_tstrb, 0);
    check("rst_busy", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int r0;
    bus.cmd_valid       = 1'b0;
    bus.cmd_addr        = '0;
    bus.cmd_len         = '0;
    bus.m03_axis_tready = 1'b1;

    // reset values while asserted, then cmd_ready rises
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_busy", bus.busy, 0);

    // basic burst: reads on consecutive cycles, first beat 2 cycles after handshake
    b0 = beat_cnt;
    send_cmd(12'h001, 12'd3);
    check("busy_in_burst", bus.busy, 1);
    check("cmd_ready_in_burst", bus.cmd_ready, 0);
    @(negedge clk);
    check("c1_rd_en", bus.m02_axis_rd_en, 1);
    check("c1_tvalid", bus.m03_axis_tvalid, 0);
    @(negedge clk);
    check("c2_rd_en", bus.m02_axis_rd_en, 1);
    check("c2_tvalid", bus.m03_axis_tvalid, 0);
    @(negedge clk);
    check("c3_rd_en", bus.m02_axis_rd_en, 1);
    check("c3_tvalid", bus.m03_axis_tvalid, 1);
    @(negedge clk);
    check("c4_rd_en", bus.m02_axis_rd_en, 1);
    @(negedge clk);
    check("c5_rd_en", bus.m02_axis_rd_en, 0);
    check("c5_tvalid", bus.m03_axis_tvalid, 1);
    wait_idle(50);
    check("basic_beats", beat_cnt - b0, 4);

    // address wrap
    b0 = beat_cnt;
    send_cmd(12'hFFE, 12'd3);
    wait_idle(50);
    check("wrap_beats", beat_cnt - b0, 4);

    // tready toggling every cycle
    b0 = beat_cnt;
    send_cmd(12'h123, 12'd7);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.m03_axis_tready = ~bus.m03_axis_tready;
    end
    bus.m03_axis_tready = 1'b1;
    wait_idle(50);
    check("toggle_beats", beat_cnt - b0, 8);

    // single-word burst
    b0 = beat_cnt;
    send_cmd(12'h0A0, 12'd0);
    wait_idle(50);
    check("single_beats", beat_cnt - b0, 1);
    check("single_cmd_ready", bus.cmd_ready, 1);
    check("single_busy", bus.busy, 0);

    // backpressure from burst start
    bus.m03_axis_tready = 1'b0;
    r0 = rd_cnt;
    b0 = beat_cnt;
    send_cmd(12'h300, 12'd3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("stall_reads_max2", (rd_cnt - r0) <= 2, 1);
    check("stall_tvalid", bus.m03_axis_tvalid, 1);
    check("stall_first_word", bus.m03_axis_tdata, data_of(12'h300));
    check("stall_no_beats", beat_cnt - b0, 0);
    bus.m03_axis_tready = 1'b1;
    wait_idle(50);
    check("stall_beats", beat_cnt - b0, 4);

    // reset mid-burst, then a fresh 2-word burst
    b0 = beat_cnt;
    send_cmd(12'h400, 12'd15);
    for (int g = 0; g < 100 && (beat_cnt - b0) < 5; g++) @(negedge clk);
    check("pre_reset_beats", beat_cnt - b0, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    addr_q.delete();
    beat_q.delete();
    #1;
    check_reset_outputs(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    b0 = beat_cnt;
    send_cmd(12'h500, 12'd1);
    wait_idle(50);
    check("after_reset_beats", beat_cnt - b0, 2);

    // maximum length burst
    b0 = beat_cnt;
    send_cmd(12'h800, 12'hFFF);
    wait_idle(5000);
    check("max_len_beats", beat_cnt - b0, 4096);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter LEN_WIDTH, default 12, burst-length field width.
REQ-004 SHALL have one clock, m03_axis_aclk, input, 1 bit; all logic on its rising edge.
REQ-005 SHALL have m03_axis_areset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have cmd_valid, input, 1 bit: burst command offered.
REQ-007 SHALL have cmd_ready, output, 1 bit: block accepts a command.
REQ-008 SHALL have cmd_addr, input, ADDR_WIDTH bits: first word address.
REQ-009 SHALL have cmd_len, input, LEN_WIDTH bits: word count minus one.
REQ-010 SHALL have m02_axis_rd_en, output, 1 bit: memory read strobe.
REQ-011 SHALL have m02_axis_rd_addr, output, ADDR_WIDTH bits: memory read address.
REQ-012 SHALL have m02_axis_rd_tdata, input, DATA_WIDTH bits: memory data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have m03_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-014 SHALL have m03_axis_tstrb, output, DATA_WIDTH/8 bits: byte strobes.
REQ-015 SHALL have m03_axis_tvalid, output, 1 bit; m03_axis_tlast, output, 1 bit; m03_axis_tready, input, 1 bit.
REQ-016 SHALL have busy, output, 1 bit: burst in progress.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-018 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches cmd_addr into address counter and cmd_len into remaining-issue counter; next state READ.
REQ-019 READ: assert rd_en with rd_addr=counter whenever output buffer free slots minus in-flight reads >= 1; each issue increments address, decrements issue counter.
REQ-020 Address counter SHALL wrap modulo 2^ADDR_WIDTH (0xFFF+1 -> 0x000); no error flag.
REQ-021 After issuing the final word (issue counter was 0) SHALL move to DRAIN; no further rd_en.
REQ-022 Returned data SHALL enter a 2-entry output FIFO; FIFO SHALL never overflow under any tready pattern.
REQ-023 tvalid=1 whenever FIFO non-empty; tdata from FIFO head; word leaves on tvalid&tready.
REQ-024 tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-025 tstrb SHALL be all ones for every beat.
REQ-026 tlast SHALL be 1 on exactly the final beat of the burst (beat cmd_len+1), carried as a FIFO tag bit.
REQ-027 DRAIN -> IDLE when FIFO empty and no read in flight; cmd_ready SHALL be 0 outside IDLE.
REQ-028 busy SHALL be 1 in READ and DRAIN, 0 in IDLE.
REQ-029 With tready held 1, throughput SHALL be one beat per cycle; first tvalid 2 cycles after command handshake.
REQ-030 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-031 cmd_len=0 SHALL produce a single beat with tlast=1.
REQ-032 cmd_len=2^LEN_WIDTH-1 SHALL produce 2^LEN_WIDTH beats without counter overflow.

Reset
REQ-033 Reset SHALL force IDLE, clear counters, FIFO and in-flight flag.
REQ-034 During and after reset: cmd_ready=0 while asserted then 1; rd_en=0, rd_addr=0, tvalid=0, tlast=0, tdata=0, tstrb=0, busy=0.
REQ-035 Reset mid-burst SHALL abandon the burst; data returning the cycle after reset SHALL be discarded.

Structure
REQ-036 FSM state encoding and default widths SHALL live in shared package mem_pkg.
REQ-037 Output FIFO SHALL be sub-module axis_fifo2 (2 entries, DATA_WIDTH+1 bits, full/empty flags).

Verification
REQ-038 cmd_addr=0x001, cmd_len=3, tready=1 -> rd_addr 0x001..0x004 on consecutive cycles; 4 beats, tlast only on beat 4.
REQ-039 cmd_addr=0xFFE, cmd_len=3 -> rd_addr 0xFFE, 0xFFF, 0x000, 0x001.
REQ-040 cmd_len=7, tready toggling 1/0 every cycle -> 8 beats in order, tdata stable while stalled, no lost or duplicate words.
REQ-041 cmd_len=0 -> one beat, tlast=1, busy falls after it, cmd_ready returns 1.
REQ-042 cmd_len=15, reset asserted after beat 5 -> all outputs to reset values at once; new cmd_len=1 afterwards yields exactly 2 beats.
REQ-043 tready=0 for 10 cycles from burst start -> at most 2 reads issued, tvalid=1 held, first word unchanged.
